// File: rtl/k12_result_checker.sv
// Result-side companion to K12_Hash: tags each launched job with its nonce, pairs it with the
// returned hash, compares the top 64 hash bits against a share target and holds winners for the host.
module k12_result_checker #(
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic               hash_valid,
  input  logic [255:0]       hash,
  input  logic [63:0]        target,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [63:0]        found_hash_hi,
  output logic [31:0]        hashes_done,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_lost
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic                 start_q, start_d;
  logic                 valid_q, valid_d;
  logic [NONCE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [NONCE_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 s1_v_q, s1_v_d;
  logic [63:0]          s1_w_q, s1_w_d;
  logic [NONCE_W-1:0]   s1_nonce_q, s1_nonce_d;
  logic                 found_valid_q, found_valid_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [63:0]          found_hash_hi_q, found_hash_hi_d;
  logic [31:0]          hashes_done_q, hashes_done_d;
  logic                 err_overflow_q, err_overflow_d;
  logic                 err_underflow_q, err_underflow_d;
  logic                 err_lost_q, err_lost_d;

  logic s_rise, v_rise, fifo_empty, fifo_full, do_push, do_pop, hit, out_free;
  logic unused_hash_bits;

  assign unused_hash_bits = ^hash[191:0];

  // Edge detection and FIFO push/pop decisions
  always_comb begin
    s_rise     = start & ~start_q;
    v_rise     = hash_valid & ~valid_q;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    do_pop     = v_rise & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    do_push    = s_rise & (~fifo_full | do_pop);
    hit        = s1_v_q & (s1_w_q < target);
    out_free   = ~found_valid_q | found_ready;
  end

  // Next-state for tag FIFO, pipeline, output register, counters and sticky flags
  always_comb begin
    start_d         = start;
    valid_d         = hash_valid;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    s1_v_d          = do_pop;
    s1_w_d          = s1_w_q;
    s1_nonce_d      = s1_nonce_q;
    found_valid_d   = found_valid_q;
    found_nonce_d   = found_nonce_q;
    found_hash_hi_d = found_hash_hi_q;
    hashes_done_d   = hashes_done_q;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    err_lost_d      = err_lost_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = nonce;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      s1_w_d     = hash[255:192];
      s1_nonce_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (s_rise & fifo_full & ~do_pop) begin
      err_overflow_d = 1'b1;
    end else begin
      err_overflow_d = err_overflow_q;
    end

    if (v_rise) begin
      hashes_done_d   = hashes_done_q + 32'd1;
      err_underflow_d = err_underflow_q | fifo_empty;
    end else begin
      hashes_done_d = hashes_done_q;
    end

    if (hit & out_free) begin
      found_valid_d   = 1'b1;
      found_nonce_d   = s1_nonce_q;
      found_hash_hi_d = s1_w_q;
    end else if (hit) begin
      err_lost_d = 1'b1;
    end else if (found_valid_q & found_ready) begin
      found_valid_d = 1'b0;
    end else begin
      found_valid_d = found_valid_q;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q         <= 1'b0;
      valid_q         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      s1_v_q          <= 1'b0;
      s1_w_q          <= 64'd0;
      s1_nonce_q      <= '0;
      found_valid_q   <= 1'b0;
      found_nonce_q   <= '0;
      found_hash_hi_q <= 64'd0;
      hashes_done_q   <= 32'd0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_lost_q      <= 1'b0;
    end else begin
      start_q         <= start_d;
      valid_q         <= valid_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      s1_v_q          <= s1_v_d;
      s1_w_q          <= s1_w_d;
      s1_nonce_q      <= s1_nonce_d;
      found_valid_q   <= found_valid_d;
      found_nonce_q   <= found_nonce_d;
      found_hash_hi_q <= found_hash_hi_d;
      hashes_done_q   <= hashes_done_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_lost_q      <= err_lost_d;
    end
  end

  assign found_valid   = found_valid_q;
  assign found_nonce   = found_nonce_q;
  assign found_hash_hi = found_hash_hi_q;
  assign hashes_done   = hashes_done_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_lost      = err_lost_q;

endmodule
